// File: rtl/branch_info_queue_pkg.sv
// Shared front-end constants and the branch-queue entry record.
package branch_info_queue_pkg;

  localparam int unsigned INST_MEM_WIDTH = 32;
  localparam int unsigned GH_WIDTH       = 8;
  localparam int unsigned PATTERN_WIDTH  = 8;
  localparam int unsigned BQ_DEPTH       = 8;

  typedef struct packed {
    logic [PATTERN_WIDTH-1:0] pattern;
    logic [1:0]               prediction;
  } bq_entry_t;

  // Bit 1 of a 2-bit PHT counter is the predicted direction.
  function automatic logic is_mispredict(input logic [1:0] prediction, input logic taken);
    return prediction[1] != taken;
  endfunction

endpackage

// File: rtl/branch_info_queue_if.sv
// Fetch/resolve/commit signal bundle between the fetch unit and the branch queue.
interface branch_info_queue_if #(
  parameter int unsigned BQ_DEPTH      = branch_info_queue_pkg::BQ_DEPTH,
  parameter int unsigned PATTERN_WIDTH = branch_info_queue_pkg::PATTERN_WIDTH
);
  localparam int unsigned CNT_W = $clog2(BQ_DEPTH) + 1;

  logic                     enq_valid;
  logic [PATTERN_WIDTH-1:0] enq_pattern;
  logic [1:0]               enq_prediction;
  logic                     full;
  logic                     resolve_valid;
  logic                     resolve_taken;
  logic                     commit_b;
  logic [PATTERN_WIDTH-1:0] pattern_end;
  logic [1:0]               prediction_end;
  logic                     failure;
  logic [CNT_W-1:0]         count;
  logic                     err;

  modport master (
    output enq_valid, enq_pattern, enq_prediction, resolve_valid, resolve_taken,
    input  full, commit_b, pattern_end, prediction_end, failure, count, err
  );

  modport slave (
    input  enq_valid, enq_pattern, enq_prediction, resolve_valid, resolve_taken,
    output full, commit_b, pattern_end, prediction_end, failure, count, err
  );

endinterface

// File: rtl/branch_info_queue.sv
// In-order queue of in-flight conditional branches; pops on resolve, emits a
// predictor-update strobe one cycle later and flushes on a mispredict.
module branch_info_queue #(
  parameter int unsigned BQ_DEPTH      = branch_info_queue_pkg::BQ_DEPTH,
  parameter int unsigned PATTERN_WIDTH = branch_info_queue_pkg::PATTERN_WIDTH
) (
  input logic                clk,
  input logic                reset,
  branch_info_queue_if.slave bq
);
  import branch_info_queue_pkg::*;

  localparam int unsigned PTR_W    = $clog2(BQ_DEPTH);
  localparam int unsigned CNT_W    = $clog2(BQ_DEPTH) + 1;
  localparam int unsigned ENTRY_PW = branch_info_queue_pkg::PATTERN_WIDTH;

  bq_entry_t                mem [BQ_DEPTH];

  logic [PTR_W-1:0]         head_q;
  logic [PTR_W-1:0]         tail_q;
  logic [CNT_W-1:0]         count_q;
  logic                     full_q;
  logic                     err_q;
  logic                     commit_q;
  logic                     failure_q;
  logic [PATTERN_WIDTH-1:0] pattern_q;
  logic [1:0]               prediction_q;

  bq_entry_t                head_entry;
  bq_entry_t                wr_entry;
  logic                     pop_c;
  logic                     mispredict_c;
  logic                     push_c;
  logic                     proto_err_c;
  logic [CNT_W-1:0]         count_nxt;

  // Accept/flush decisions for this cycle; full is the registered flag, so a
  // same-cycle pop never frees a slot for the enqueue.
  always_comb begin
    head_entry        = mem[head_q];
    wr_entry.pattern    = ENTRY_PW'(bq.enq_pattern);
    wr_entry.prediction = bq.enq_prediction;
    pop_c        = bq.resolve_valid && (count_q != '0);
    mispredict_c = pop_c && is_mispredict(head_entry.prediction, bq.resolve_taken);
    push_c       = bq.enq_valid && !full_q && !failure_q && !mispredict_c;
    proto_err_c  = (bq.enq_valid && full_q) || (bq.resolve_valid && (count_q == '0));
    count_nxt    = count_q;
    if (mispredict_c) begin
      count_nxt = '0;
    end else if (push_c && !pop_c) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  // Pointer, occupancy and commit-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      commit_q     <= 1'b0;
      failure_q    <= 1'b0;
      pattern_q    <= '0;
      prediction_q <= '0;
    end else begin
      commit_q  <= pop_c;
      failure_q <= mispredict_c;
      if (pop_c) begin
        pattern_q    <= PATTERN_WIDTH'(head_entry.pattern);
        prediction_q <= head_entry.prediction;
      end
      if (proto_err_c) begin
        err_q <= 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(BQ_DEPTH));
      if (mispredict_c) begin
        head_q <= tail_q;
      end else begin
        if (pop_c) begin
          head_q <= head_q + PTR_W'(1);
        end
        if (push_c) begin
          tail_q <= tail_q + PTR_W'(1);
        end
      end
    end
  end

  // Entry storage carries no reset; slots are only read while occupied.
  always_ff @(posedge clk) begin
    if (push_c && !reset) begin
      mem[tail_q] <= wr_entry;
    end
  end

  assign bq.full           = full_q;
  assign bq.err            = err_q;
  assign bq.count          = count_q;
  assign bq.commit_b       = commit_q;
  assign bq.failure        = failure_q;
  assign bq.pattern_end    = pattern_q;
  assign bq.prediction_end = prediction_q;

endmodule

// File: tb/tb_branch_info_queue.sv
// Directed and randomized checks of branch_info_queue against a queue-based model.
module tb_branch_info_queue;
  import branch_info_queue_pkg::*;

  localparam int unsigned DEPTH = BQ_DEPTH;
  localparam int unsigned PW    = PATTERN_WIDTH;

  typedef struct {
    logic [PW-1:0] pat;
    logic [1:0]    pred;
  } ent_t;

  logic clk;
  logic reset;

  branch_info_queue_if #(.BQ_DEPTH(DEPTH), .PATTERN_WIDTH(PW)) bif ();

  branch_info_queue #(.BQ_DEPTH(DEPTH), .PATTERN_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bq    (bif.slave)
  );

  int total = 0;
  int bad   = 0;

  ent_t          mq[$];
  logic          m_commit = 1'b0;
  logic          m_fail   = 1'b0;
  logic          m_err    = 1'b0;
  logic [PW-1:0] m_pat    = '0;
  logic [1:0]    m_pred   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, from the pre-edge model state.
  task automatic model_edge(input logic ev, input logic [PW-1:0] ep, input logic [1:0] epr,
                            input logic rv, input logic rt, input logic rst);
    int  sz;
    bit  pop;
    bit  mis;
    bit  push;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_commit = 1'b0;
      m_fail   = 1'b0;
      m_err    = 1'b0;
      m_pat    = '0;
      m_pred   = '0;
    end else begin
      sz   = mq.size();
      pop  = rv && (sz != 0);
      mis  = pop && (mq[0].pred[1] != rt);
      push = ev && (sz < int'(DEPTH)) && !m_fail && !mis;
      if ((ev && sz == int'(DEPTH)) || (rv && sz == 0)) m_err = 1'b1;
      if (pop) begin
        m_pat  = mq[0].pat;
        m_pred = mq[0].pred;
      end
      m_commit = pop;
      m_fail   = mis;
      if (mis) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.pat  = ep;
          e.pred = epr;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".commit_b"}, 32'(bif.commit_b), 32'(m_commit));
    chk({tag, ".failure"}, 32'(bif.failure), 32'(m_fail));
    chk({tag, ".count"}, 32'(bif.count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(bif.full), 32'(mq.size() == int'(DEPTH)));
    chk({tag, ".err"}, 32'(bif.err), 32'(m_err));
    chk({tag, ".pattern_end"}, 32'(bif.pattern_end), 32'(m_pat));
    chk({tag, ".prediction_end"}, 32'(bif.prediction_end), 32'(m_pred));
  endtask

  task automatic step(input string tag, input logic ev, input logic [PW-1:0] ep,
                      input logic [1:0] epr, input logic rv, input logic rt, input logic rst);
    bif.enq_valid      = ev;
    bif.enq_pattern    = ep;
    bif.enq_prediction = epr;
    bif.resolve_valid  = rv;
    bif.resolve_taken  = rt;
    reset              = rst;
    @(posedge clk);
    model_edge(ev, ep, epr, rv, rt, rst);
    #1;
    check_all(tag);
  endtask

  task automatic enq(input string tag, input logic [PW-1:0] ep, input logic [1:0] epr);
    step(tag, 1'b1, ep, epr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic res(input string tag, input logic rt);
    step(tag, 1'b0, '0, 2'b00, 1'b1, rt, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic          ev;
    logic          rv;
    logic          rt;
    logic          rst;
    logic [PW-1:0] ep;
    logic [1:0]    epr;

    bif.enq_valid      = 1'b0;
    bif.enq_pattern    = '0;
    bif.enq_prediction = '0;
    bif.resolve_valid  = 1'b0;
    bif.resolve_taken  = 1'b0;
    reset              = 1'b1;

    // Reset state
    do_reset("rst0");
    do_reset("rst1");
    chk("rst.count", 32'(bif.count), 32'd0);
    chk("rst.commit_b", 32'(bif.commit_b), 32'd0);

    // Single correctly predicted branch
    enq("c33_enq", PW'(8'h12), 2'b11);
    res("c33_res", 1'b1);
    chk("c33.commit_b", 32'(bif.commit_b), 32'd1);
    chk("c33.pattern_end", 32'(bif.pattern_end), 32'h12);
    chk("c33.prediction_end", 32'(bif.prediction_end), 32'd3);
    chk("c33.failure", 32'(bif.failure), 32'd0);
    chk("c33.count", 32'(bif.count), 32'd0);
    idle("c33_idle");
    chk("c33.commit_off", 32'(bif.commit_b), 32'd0);

    // Mispredict flush, enqueue in the resolve cycle and the failure cycle dropped
    enq("c34_e0", PW'(8'h21), 2'b01);
    enq("c34_e1", PW'(8'h22), 2'b11);
    enq("c34_e2", PW'(8'h23), 2'b10);
    step("c34_res", 1'b1, PW'(8'h30), 2'b11, 1'b1, 1'b1, 1'b0);
    chk("c34.failure", 32'(bif.failure), 32'd1);
    chk("c34.count", 32'(bif.count), 32'd0);
    chk("c34.pattern_end", 32'(bif.pattern_end), 32'h21);
    enq("c34_wrong_path", PW'(8'h31), 2'b11);
    chk("c34.count_after", 32'(bif.count), 32'd0);
    idle("c34_idle");

    // Fill, overflow, then drain to confirm contents untouched
    for (int i = 0; i < int'(DEPTH); i++) enq("c35_fill", PW'(8'h50 + i), 2'(i | 2));
    chk("c35.full", 32'(bif.full), 32'd1);
    enq("c35_over", PW'(8'hEE), 2'b11);
    chk("c35.err", 32'(bif.err), 32'd1);
    chk("c35.count", 32'(bif.count), 32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      res("c35_drain", 1'b1);
      chk("c35.drain_pat", 32'(bif.pattern_end), 32'(8'h50 + i));
    end

    // Resolve while empty, then reset clears err
    do_reset("c37_rst_a");
    res("c37_empty", 1'b1);
    chk("c37.commit_b", 32'(bif.commit_b), 32'd0);
    chk("c37.err", 32'(bif.err), 32'd1);
    do_reset("c37_rst_b");
    chk("c37.err_clr", 32'(bif.err), 32'd0);

    // Full queue with resolve/enqueue pairs across pointer wrap
    for (int i = 0; i < int'(DEPTH); i++) enq("c36_fill", PW'(i), 2'b10);
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      res("c36_res", 1'b1);
      chk("c36.fifo_pat", 32'(bif.pattern_end), 32'(PW'(i)));
      enq("c36_enq", PW'(int'(DEPTH) + i), 2'b10);
      chk("c36.count", 32'(bif.count), 32'(DEPTH));
    end

    // Simultaneous push/pop: when full the push is refused, otherwise count holds
    step("c24_full", 1'b1, PW'(8'hA0), 2'b11, 1'b1, 1'b1, 1'b0);
    chk("c24.full_count", 32'(bif.count), 32'(DEPTH - 1));
    chk("c24.full_err", 32'(bif.err), 32'd1);
    step("c24_part", 1'b1, PW'(8'hA1), 2'b11, 1'b1, 1'b1, 1'b0);
    chk("c24.part_count", 32'(bif.count), 32'(DEPTH - 1));

    // Reset beats a mispredicting resolve
    do_reset("c38_rst_a");
    enq("c38_enq", PW'(8'h40), 2'b01);
    step("c38_rst_res", 1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("c38.commit_b", 32'(bif.commit_b), 32'd0);
    chk("c38.failure", 32'(bif.failure), 32'd0);
    chk("c38.count", 32'(bif.count), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      ev  = 1'(($urandom % 3) != 0);
      ep  = PW'($urandom);
      epr = 2'($urandom);
      rv  = 1'(($urandom % 2) != 0);
      if (mq.size() != 0 && ($urandom % 8) != 0) rt = mq[0].pred[1];
      else rt = 1'($urandom);
      rst = 1'(($urandom % 80) == 0);
      step("rand", ev, ep, epr, rv, rt, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
